// File: rtl/ram_frame_loader.sv
// ram_frame_loader: UART byte stream to parameter RAM sequencer.
// Parses AA + payload + checksum frames and commits good frames.
module ram_frame_loader #(
    parameter int         NUM_BYTES   = 113,
    parameter logic [7:0] HDR_BYTE    = 8'hAA,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ram_din,
    output logic [7:0] ram_w_addr,
    output logic       ram_write,
    output logic       ram_read,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int CW = $clog2(NUM_BYTES);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BYTES - 1);
    localparam logic [7:0]    TOP_ADDR = 8'(NUM_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [1:0] ERR_SUM = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [7:0]    sum;
    logic [TW-1:0] timer;
    logic          commit_ph;

    logic hdr_hit;
    logic in_frame;
    logic load_acc;
    logic last_acc;
    logic chk_acc;
    logic sum_ok;
    logic tmo;
    logic commit_go;

    // Per-cycle events derived from the current state and Rx strobe.
    assign hdr_hit   = (state == S_IDLE) && rx_valid && (rx_data == HDR_BYTE);
    assign in_frame  = (state == S_LOAD) || (state == S_CHECK);
    assign load_acc  = (state == S_LOAD) && rx_valid;
    assign last_acc  = load_acc && (cnt == LAST_CNT);
    assign chk_acc   = (state == S_CHECK) && rx_valid;
    assign sum_ok    = (rx_data == sum);
    assign tmo       = in_frame && !rx_valid && (timer == TMO_LAST);
    assign commit_go = chk_acc && sum_ok;
    assign busy      = (state != S_IDLE);

    // Next-state selection; an arriving byte always beats the timeout.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (hdr_hit) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (tmo)           state_nx = S_IDLE;
                else if (last_acc) state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (tmo)          state_nx = S_IDLE;
                else if (chk_acc) state_nx = sum_ok ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: begin
                if (commit_ph) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Payload byte counter and running 8-bit checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sum <= '0;
        end else if (hdr_hit) begin
            cnt <= '0;
            sum <= '0;
        end else if (load_acc) begin
            cnt <= cnt + CW'(1);
            sum <= sum + rx_data;
        end
    end

    // Inter-byte silence timer, only live inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         timer <= '0;
        else if (!in_frame || rx_valid || tmo) timer <= '0;
        else                                timer <= timer + TW'(1);
    end

    // RAM write port: payload is stored top address first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_write  <= 1'b0;
            ram_w_addr <= '0;
            ram_din    <= '0;
        end else begin
            ram_write <= load_acc;
            if (load_acc) begin
                ram_w_addr <= TOP_ADDR - 8'(cnt);
                ram_din    <= rx_data;
            end
        end
    end

    // Commit: two-cycle read strobe, frame_ok on the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_ph <= 1'b0;
            ram_read  <= 1'b0;
            frame_ok  <= 1'b0;
        end else begin
            commit_ph <= (state == S_COMMIT) && !commit_ph;
            ram_read  <= commit_go || ((state == S_COMMIT) && !commit_ph);
            frame_ok  <= commit_go;
        end
    end

    // Rejection pulse and sticky cause code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            frame_err <= tmo || (chk_acc && !sum_ok);
            if (tmo)                    err_code <= ERR_TMO;
            else if (chk_acc && !sum_ok) err_code <= ERR_SUM;
        end
    end

endmodule

// File: tb/tb_ram_frame_loader.sv
// tb_ram_frame_loader: randomized frames vs a frame-level model,
// expected RAM events scoreboarded and checked by a monitor.
module tb_ram_frame_loader;

    localparam int         NB  = 113;
    localparam int         TMO = 64;
    localparam logic [7:0] HDR = 8'hAA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] ram_din;
    logic [7:0] ram_w_addr;
    logic       ram_write;
    logic       ram_read;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    ram_frame_loader #(
        .NUM_BYTES  (NB),
        .HDR_BYTE   (HDR),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ram_din   (ram_din),
        .ram_w_addr(ram_w_addr),
        .ram_write (ram_write),
        .ram_read  (ram_read),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    int checks = 0;
    int failures = 0;
    int commits_exp = 0;
    int rr_runs = 0;
    int rr_run = 0;

    // event encoding: {kind[1:0], addr[7:0], data[7:0]}
    logic [17:0] exp_q[$];
    logic [7:0]  model_ram[NB];
    logic [7:0]  dut_ram[NB];
    logic [7:0]  pl[NB];
    logic [17:0] e;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [17:0] pop_exp();
        if (exp_q.size() == 0) return '1;
        return exp_q.pop_front();
    endfunction

    // monitor: compare every DUT output event against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_write) begin
                e = pop_exp();
                check("write_evt", {14'h0, 2'b00, ram_w_addr, ram_din},
                      {14'h0, e});
                if (int'(ram_w_addr) < NB) dut_ram[ram_w_addr] = ram_din;
            end
            if (frame_ok) begin
                int bad;
                e = pop_exp();
                check("commit_evt",
                      {14'h0, 1'b0, frame_ok, 8'h00, 7'h00, ram_write},
                      {14'h0, e});
                check("ok_with_read", {31'h0, ram_read}, 1);
                bad = 0;
                for (int i = 0; i < NB; i++)
                    if (dut_ram[i] !== model_ram[i]) bad++;
                check("ram_image", bad, 0);
            end
            if (frame_err) begin
                e = pop_exp();
                check("err_evt",
                      {14'h0, frame_err, 1'b0, 8'h00, 6'h00, err_code},
                      {14'h0, e});
            end
            if (ram_read) begin
                rr_run++;
                check("rd_wr_excl", {31'h0, ram_write}, 0);
            end else if (rr_run != 0) begin
                check("read_width", rr_run, 2);
                rr_runs++;
                rr_run = 0;
            end
        end else begin
            rr_run = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // model: byte k lands at address NB-1-k
    task automatic load_payload(input int n, input int bnd_idx);
        for (int k = 0; k < n; k++) begin
            model_ram[NB-1-k] = pl[k];
            exp_q.push_back({2'b00, 8'(NB - 1 - k), pl[k]});
            send_byte(pl[k], (k == bnd_idx) ? TMO - 1 : $urandom_range(0, 2));
        end
    endtask

    task automatic finish_frame(input bit good, input int bnd_idx);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < NB; k++) s = s + pl[k];
        load_payload(NB, bnd_idx);
        if (good) begin
            exp_q.push_back({2'b01, 16'h0000});
            commits_exp++;
            send_byte(s, $urandom_range(0, 2));
        end else begin
            exp_q.push_back({2'b10, 8'h00, 8'h01});
            send_byte(s + 8'($urandom_range(1, 255)), $urandom_range(0, 2));
        end
        repeat (4) @(negedge clk);
        check("busy_after", {31'h0, busy}, 0);
        check("q_drained", exp_q.size(), 0);
        if (!good) check("err_code_sum", {30'h0, err_code}, 2'b01);
    endtask

    task automatic send_frame(input bit good, input int bnd_idx);
        send_byte(HDR, 1);
        finish_frame(good, bnd_idx);
    endtask

    task automatic rand_payload();
        for (int k = 0; k < NB; k++)
            pl[k] = ($urandom_range(0, 9) == 0) ? HDR : 8'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < NB; i++) begin
            dut_ram[i] = 8'h00;
            model_ram[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_strobes",
              {26'h0, ram_write, ram_read, busy, frame_ok, frame_err, 1'b0},
              0);
        check("rst_err_code", {30'h0, err_code}, 0);
        check("rst_din_addr", {16'h0, ram_din, ram_w_addr}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // counting payload, good then bad checksum
        for (int k = 0; k < NB; k++) pl[k] = 8'(k);
        send_frame(1'b1, -1);
        send_frame(1'b0, -1);

        // stall after 50 bytes
        rand_payload();
        send_byte(HDR, 1);
        load_payload(50, -1);
        exp_q.push_back({2'b10, 8'h00, 8'h02});
        cyc = 0;
        while (!frame_err && cyc < 4 * TMO) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, TMO);
        repeat (2) @(negedge clk);
        check("err_code_tmo", {30'h0, err_code}, 2'b10);
        check("busy_tmo", {31'h0, busy}, 0);
        check("q_tmo", exp_q.size(), 0);
        rand_payload();
        send_frame(1'b1, -1);

        // junk in idle is ignored, header starts a frame
        send_byte(8'h55, 1);
        send_byte(8'h00, 1);
        repeat (2) @(negedge clk);
        check("idle_junk_busy", {31'h0, busy}, 0);
        send_byte(HDR, 0);
        check("hdr_busy", {31'h0, busy}, 1);
        rand_payload();
        finish_frame(1'b1, -1);

        // all-FF payload
        for (int k = 0; k < NB; k++) pl[k] = 8'hFF;
        send_frame(1'b1, -1);
        check("addr0_ff", {24'h0, dut_ram[0]}, 8'hFF);

        // byte arriving on the last timeout cycle is accepted
        rand_payload();
        send_frame(1'b1, 5);

        // random frames
        for (int f = 0; f < 6; f++) begin
            rand_payload();
            send_frame($urandom_range(0, 2) != 0, -1);
        end

        // async reset mid-frame
        rand_payload();
        send_byte(HDR, 1);
        load_payload(30, -1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_strobes",
              {26'h0, ram_write, ram_read, busy, frame_ok, frame_err, 1'b0},
              0);
        check("midrst_err_code", {30'h0, err_code}, 0);
        check("midrst_q", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rand_payload();
        send_frame(1'b1, -1);

        repeat (4) @(negedge clk);
        check("commit_count", rr_runs, commits_exp);
        check("q_final", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
